// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg
// Shared definitions for the multi-port register file.
//   - Default geometry (data width, address width, read port count).
//   - rf_lane_t: one write port's contribution to a single byte lane.
//   - rf_merge_byte: resolves two write ports onto one stored byte with
//     port 1 taking priority. The storage write path and the bypass read
//     path both call it, so they always agree on the merged value.
// ---------------------------------------------------------------------------
package rf_pkg;

    localparam int RF_DW_DEF = 32;
    localparam int RF_AW_DEF = 5;
    localparam int RF_NR_DEF = 2;

    // One byte lane of one write port: enable already qualified by
    // we, the address match and the byte enable.
    typedef struct packed {
        logic       en;
        logic [7:0] d;
    } rf_lane_t;

    // Port 1 wins any byte both ports write; port 0 bytes land only where
    // port 1 leaves the lane alone; untouched lanes keep their old value.
    function automatic logic [7:0] rf_merge_byte(
        input logic [7:0] old_byte,
        input rf_lane_t   lane0,
        input rf_lane_t   lane1
    );
        logic [7:0] res;
        res = old_byte;
        if (lane1.en) begin
            res = lane1.d;
        end else if (lane0.en) begin
            res = lane0.d;
        end
        return res;
    endfunction

endpackage

// File: rtl/regfile_mp_read.sv
// ---------------------------------------------------------------------------
// rf_read_port
// One read port of regfile_mp.
//   wrclk, clrn : clock and asynchronous active-low reset (only used when the
//                 data output is registered)
//   ra          : read address
//   store       : flattened stored words, word j at [j*DW +: DW]
//   view        : flattened stored words merged with this cycle's writes
//   busy        : per-register busy bits
//   wr_hit      : per-register "some write port targets it this cycle"
//   iss_hit     : per-register "an issue targets it this cycle"
//   rdata       : read data (combinational or one-cycle registered)
//   rbusy       : busy bit of ra, always combinational
// ---------------------------------------------------------------------------
module rf_read_port #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int BYPASS   = 1,
    parameter int READ_REG = 0
) (
    input  logic                   wrclk,
    input  logic                   clrn,
    input  logic [AW-1:0]          ra,
    input  logic [(2**AW)*DW-1:0]  store,
    input  logic [(2**AW)*DW-1:0]  view,
    input  logic [(2**AW)-1:0]     busy,
    input  logic [(2**AW)-1:0]     wr_hit,
    input  logic [(2**AW)-1:0]     iss_hit,
    output logic [DW-1:0]          rdata,
    output logic                   rbusy
);

    logic [DW-1:0] sel_data;
    int            sel_idx;

    // Pick the word for this port. With bypass the merged view is used, so a
    // consumer sees a same-cycle write. A register being written this cycle
    // is reported not-busy under bypass, unless a new producer is issued onto
    // it in the same cycle, because that producer is still outstanding.
    always_comb begin
        sel_idx  = int'(ra);
        sel_data = (BYPASS != 0) ? view[sel_idx*DW +: DW] : store[sel_idx*DW +: DW];
        rbusy    = busy[ra];
        if ((BYPASS != 0) && wr_hit[ra] && !iss_hit[ra]) begin
            rbusy = 1'b0;
        end
    end

    // Either hand the selected word straight out, or capture it on the clock
    // edge for a one-cycle-latency read that clears on reset.
    if (READ_REG != 0) begin : g_reg
        always_ff @(posedge wrclk or negedge clrn) begin
            if (!clrn) begin
                rdata <= '0;
            end else begin
                rdata <= sel_data;
            end
        end
    end else begin : g_comb
        assign rdata = sel_data;
    end

endmodule

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
// Parametrised multi-port register file with two byte-enabled write ports,
// optional write-to-read bypass, optional registered reads and a per-register
// busy scoreboard for hazard detection.
//   wrclk      : clock, all state updates on the rising edge
//   clrn       : asynchronous active-low reset, clears words, busy bits and
//                registered read data
//   ra         : NR read addresses, port i at [i*AW +: AW]
//   rdata      : NR read words, port i at [i*DW +: DW]
//   rbusy      : busy bit for each read address
//   we0/we1    : write enables
//   wa0/wa1    : write addresses
//   wd0/wd1    : write data
//   wbe0/wbe1  : byte enables, bit k covers bits [8k+7:8k]
//   iss_en     : mark iss_rd busy (producer issued)
//   iss_rd     : register to mark busy
// ---------------------------------------------------------------------------
module regfile_mp
    import rf_pkg::*;
#(
    parameter int DW       = RF_DW_DEF,
    parameter int AW       = RF_AW_DEF,
    parameter int NR       = RF_NR_DEF,
    parameter int BYPASS   = 1,
    parameter int READ_REG = 0,
    parameter int ZERO_REG = 1
) (
    input  logic              wrclk,
    input  logic              clrn,
    input  logic [NR*AW-1:0]  ra,
    output logic [NR*DW-1:0]  rdata,
    output logic [NR-1:0]     rbusy,
    input  logic              we0,
    input  logic              we1,
    input  logic [AW-1:0]     wa0,
    input  logic [AW-1:0]     wa1,
    input  logic [DW-1:0]     wd0,
    input  logic [DW-1:0]     wd1,
    input  logic [DW/8-1:0]   wbe0,
    input  logic [DW/8-1:0]   wbe1,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_rd
);

    localparam int DEPTH = 2**AW;
    localparam int NB    = DW / 8;

    logic [DW-1:0]       mem [DEPTH];
    logic [DEPTH-1:0]    busy;
    logic [DEPTH-1:0]    busy_next;
    logic [DEPTH-1:0]    wr_hit;
    logic [DEPTH-1:0]    iss_hit;
    logic [DEPTH*DW-1:0] store_flat;
    logic [DEPTH*DW-1:0] view_flat;
    rf_lane_t            lane0;
    rf_lane_t            lane1;

    // Build the "after this edge" view of every register. This single view
    // is both what storage loads at the edge and what bypassed reads return,
    // so the two can never disagree about collisions. Register 0 is pinned
    // to zero when it is the hardwired zero register, which also drops any
    // write aimed at it. Issue beats write on the busy bit so a freshly
    // issued producer stays outstanding even if an older one retires now.
    always_comb begin
        store_flat = '0;
        view_flat  = '0;
        wr_hit     = '0;
        iss_hit    = '0;
        busy_next  = '0;
        lane0      = '0;
        lane1      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            store_flat[i*DW +: DW] = mem[i];
            for (int k = 0; k < NB; k++) begin
                lane0.en = we0 && (wa0 == AW'(i)) && wbe0[k];
                lane0.d  = wd0[k*8 +: 8];
                lane1.en = we1 && (wa1 == AW'(i)) && wbe1[k];
                lane1.d  = wd1[k*8 +: 8];
                view_flat[i*DW + k*8 +: 8] = rf_merge_byte(mem[i][k*8 +: 8], lane0, lane1);
            end
            wr_hit[i]    = (we0 && (wa0 == AW'(i))) || (we1 && (wa1 == AW'(i)));
            iss_hit[i]   = iss_en && (iss_rd == AW'(i)) && !((ZERO_REG != 0) && (i == 0));
            busy_next[i] = iss_hit[i] || (busy[i] && !wr_hit[i]);
        end
        if (ZERO_REG != 0) begin
            view_flat[DW-1:0] = '0;
        end
    end

    // Storage and busy scoreboard. Reset is asynchronous and wipes anything
    // in flight; otherwise every word simply loads its merged view.
    always_ff @(posedge wrclk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            busy <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= view_flat[i*DW +: DW];
            end
            busy <= busy_next;
        end
    end

    // One independent read port per requested port.
    for (genvar g = 0; g < NR; g++) begin : g_rd
        rf_read_port #(
            .DW       (DW),
            .AW       (AW),
            .BYPASS   (BYPASS),
            .READ_REG (READ_REG)
        ) u_rd (
            .wrclk   (wrclk),
            .clrn    (clrn),
            .ra      (ra[g*AW +: AW]),
            .store   (store_flat),
            .view    (view_flat),
            .busy    (busy),
            .wr_hit  (wr_hit),
            .iss_hit (iss_hit),
            .rdata   (rdata[g*DW +: DW]),
            .rbusy   (rbusy[g])
        );
    end

endmodule
